// File: rtl/alu_4bit_driver.sv
// alu_4bit_driver: takes valid/ready ALU commands, holds them on the ALU pins for SETTLE_CYCLES, then queues the sampled {flags,result} byte in a FWFT FIFO.
// Defining ALU_DRV_STATS_EN builds the stat_cmds/stat_carry counters; otherwise both outputs are tied to zero.
module alu_4bit_driver #(
  parameter int SETTLE_CYCLES = 2,
  parameter int FIFO_DEPTH    = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [3:0] cmd_a,
  input  logic [3:0] cmd_b,
  input  logic [3:0] cmd_sel,
  output logic [7:0] alu_ui,
  output logic [7:0] alu_uio,
  input  logic [7:0] alu_uo,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [7:0] rsp_data,
  output logic       busy,
  output logic [7:0] stat_cmds,
  output logic [7:0] stat_carry
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [3:0]    SETTLE_M1 = 4'(SETTLE_CYCLES - 1);
  localparam logic [CW-1:0] FULL_CNT  = CW'(FIFO_DEPTH);

  typedef enum logic {S_IDLE, S_DRIVE} state_t;

  state_t        r_state, w_state_nxt;
  logic [3:0]    r_cnt;
  logic [7:0]    r_alu_ui, r_alu_uio;
  logic          r_cmd_rdy;
  logic [7:0]    r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wr_ptr, r_rd_ptr;
  logic [CW-1:0] r_count, w_count_nxt;
  logic          w_accept, w_push, w_pop;

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_push      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (cmd_valid && r_cmd_rdy) begin
          w_accept    = 1'b1;
          w_state_nxt = S_DRIVE;
        end
      end
      S_DRIVE: begin
        if (r_cnt == 4'd0) begin
          w_push      = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign w_pop = (r_count != '0) && rsp_ready;

  always_comb begin
    w_count_nxt = r_count;
    if (w_push && !w_pop) begin
      w_count_nxt = r_count + CW'(1);
    end else if (!w_push && w_pop) begin
      w_count_nxt = r_count - CW'(1);
    end
  end

  // cmd_ready is registered from the next state/occupancy, so it is low during reset
  // and only rises once the FSM is idle with a free FIFO slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_cnt     <= 4'd0;
      r_alu_ui  <= 8'h00;
      r_alu_uio <= 8'h00;
      r_cmd_rdy <= 1'b0;
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_count   <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_cmd_rdy <= (w_state_nxt == S_IDLE) && (w_count_nxt != FULL_CNT);
      r_count   <= w_count_nxt;
      if (w_accept) begin
        r_alu_ui  <= {cmd_b, cmd_a};
        r_alu_uio <= {4'h0, cmd_sel};
        r_cnt     <= SETTLE_M1;
      end else if (r_state == S_DRIVE && r_cnt != 4'd0) begin
        r_cnt <= r_cnt - 4'd1;
      end
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= alu_uo;
  end

  assign cmd_ready = r_cmd_rdy;
  assign alu_ui    = r_alu_ui;
  assign alu_uio   = r_alu_uio;
  assign busy      = (r_state == S_DRIVE);
  assign rsp_valid = (r_count != '0);
  assign rsp_data  = rsp_valid ? r_mem[r_rd_ptr] : 8'h00;

`ifdef ALU_DRV_STATS_EN
  logic [7:0] r_stat_cmds, r_stat_carry;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stat_cmds  <= 8'h00;
      r_stat_carry <= 8'h00;
    end else begin
      if (w_accept)              r_stat_cmds  <= r_stat_cmds + 8'd1;
      if (w_push && alu_uo[7])   r_stat_carry <= r_stat_carry + 8'd1;
    end
  end

  assign stat_cmds  = r_stat_cmds;
  assign stat_carry = r_stat_carry;
`else
  assign stat_cmds  = 8'h00;
  assign stat_carry = 8'h00;
`endif

endmodule

// File: tb/tb_alu_4bit_driver.sv
// Scoreboard bench for alu_4bit_driver: the stimulus side queues expected response bytes, a monitor pops and compares on every rsp handshake.
module tb_alu_4bit_driver;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [3:0] cmd_a = 4'h0, cmd_b = 4'h0, cmd_sel = 4'h0;
  logic [7:0] alu_ui, alu_uio, alu_uo;
  logic       rsp_valid;
  logic       rsp_ready = 1'b0;
  logic [7:0] rsp_data;
  logic       busy;
  logic [7:0] stat_cmds, stat_carry;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  logic [7:0] exp_q[$];
  logic       force_en = 1'b0;
  logic [7:0] force_val = 8'h00;

  alu_4bit_driver #(.SETTLE_CYCLES(2), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_sel(cmd_sel),
    .alu_ui(alu_ui), .alu_uio(alu_uio), .alu_uo(alu_uo),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .busy(busy), .stat_cmds(stat_cmds), .stat_carry(stat_carry)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ALU stand-in: flags nibble echoes sel, result is A-B; can be overridden with a fixed byte.
  always_comb begin
    alu_uo = {alu_uio[3:0], alu_ui[3:0] - alu_ui[7:4]};
    if (force_en) alu_uo = force_val;
  end

  function automatic void chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%02h expected 0x%02h", name, act, exp);
    end
  endfunction

  function automatic logic [7:0] exp_of(input logic [3:0] a, input logic [3:0] b, input logic [3:0] sel);
    logic [3:0] r;
    r = a - b;
    return {sel, r};
  endfunction

  always @(negedge clk) begin
    if (rst_n && rsp_valid && rsp_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL rsp_unexpected: got 0x%02h with no response outstanding", rsp_data);
      end else begin
        chk("rsp_data", rsp_data, exp_q.pop_front());
      end
    end
  end

  task automatic issue(input logic [3:0] a, input logic [3:0] b, input logic [3:0] sel, input logic [7:0] e);
    cmd_a = a; cmd_b = b; cmd_sel = sel; cmd_valid = 1'b1;
    exp_q.push_back(e);
  endtask

  task automatic wait_accept(output int acc_cyc);
    logic ok;
    ok = 1'b0;
    for (int n = 0; n <= 200; n++) begin
      @(negedge clk);
      if (cmd_ready) begin ok = 1'b1; break; end
    end
    chk("accept_timeout", {7'b0, ~ok}, 8'h00);
    @(posedge clk);
    #1;
    acc_cyc = cyc;
    cmd_valid = 1'b0;
  endtask

  task automatic send(input logic [3:0] a, input logic [3:0] b, input logic [3:0] sel, input logic [7:0] e);
    int dummy;
    issue(a, b, sel, e);
    wait_accept(dummy);
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || rsp_valid) && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("drain_timeout", {7'b0, (n >= 500)}, 8'h00);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc, prev;
    logic [3:0] s;

    // Reset values
    repeat (2) @(negedge clk);
    chk("rst_alu_ui", alu_ui, 8'h00);
    chk("rst_alu_uio", alu_uio, 8'h00);
    chk("rst_rsp_valid", {7'b0, rsp_valid}, 8'h00);
    chk("rst_rsp_data", rsp_data, 8'h00);
    chk("rst_busy", {7'b0, busy}, 8'h00);
    chk("rst_cmd_ready", {7'b0, cmd_ready}, 8'h00);
    chk("rst_stat_cmds", stat_cmds, 8'h00);
    chk("rst_stat_carry", stat_carry, 8'h00);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_cmd_ready", {7'b0, cmd_ready}, 8'h01);
    @(posedge clk); #1;

    // Basic: 3,5,sel0 with the ALU forced to 0x08
    force_en = 1'b1; force_val = 8'h08;
    send(4'h3, 4'h5, 4'h0, 8'h08);
    @(negedge clk);
    chk("basic_alu_ui", alu_ui, 8'h53);
    chk("basic_alu_uio", alu_uio, 8'h00);
    chk("basic_busy_c1", {7'b0, busy}, 8'h01);
    chk("basic_rsp_early1", {7'b0, rsp_valid}, 8'h00);
    @(negedge clk);
    chk("basic_busy_c2", {7'b0, busy}, 8'h01);
    chk("basic_rsp_early2", {7'b0, rsp_valid}, 8'h00);
    @(negedge clk);
    chk("basic_busy_done", {7'b0, busy}, 8'h00);
    chk("basic_rsp_valid", {7'b0, rsp_valid}, 8'h01);
    chk("basic_rsp_data", rsp_data, 8'h08);
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    wait_drain();

    // Stability: ALU output changes one cycle before the sampling edge
    @(posedge clk); #1;
    force_val = 8'h11;
    send(4'h9, 4'h2, 4'h5, 8'h8F);
    @(negedge clk);
    chk("stab_alu_ui_c1", alu_ui, 8'h29);
    chk("stab_alu_uio_c1", alu_uio, 8'h05);
    @(posedge clk); #1;
    force_val = 8'h8F;
    @(negedge clk);
    chk("stab_alu_ui_c2", alu_ui, 8'h29);
    chk("stab_alu_uio_c2", alu_uio, 8'h05);
    chk("stab_busy_c2", {7'b0, busy}, 8'h01);
    wait_drain();
    force_en = 1'b0;

    // Full: four queued, fifth held until a single pop
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    send(4'h7, 4'h2, 4'h1, 8'h15);
    send(4'h2, 4'h7, 4'h2, 8'h2B);
    send(4'hF, 4'hF, 4'h3, 8'h30);
    send(4'h0, 4'h1, 4'h8, 8'h8F);
    issue(4'hA, 4'h3, 4'hC, 8'hC7);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("full_cmd_ready_low", {7'b0, cmd_ready}, 8'h00);
    end
    chk("full_rsp_valid", {7'b0, rsp_valid}, 8'h01);
    chk("full_head", rsp_data, 8'h15);
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    wait_accept(acc);
    rsp_ready = 1'b1;
    wait_drain();

    // Simultaneous: start full, hold rsp_ready, 20 back-to-back commands
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      send(4'(i + 4), 4'(i), 4'(i + 2), exp_of(4'(i + 4), 4'(i), 4'(i + 2)));
    end
    repeat (3) @(negedge clk);
    chk("sim_full_cmd_ready", {7'b0, cmd_ready}, 8'h00);
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    prev = 0;
    for (int i = 0; i < 20; i++) begin
      issue(4'(i), 4'(i * 3), 4'(i + 1), exp_of(4'(i), 4'(i * 3), 4'(i + 1)));
      wait_accept(acc);
      if (i > 0) chk("sim_accept_gap", 8'(acc - prev), 8'd3);
      prev = acc;
    end
    wait_drain();

    // Reset mid-DRIVE with two entries queued
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    send(4'h1, 4'h1, 4'h6, 8'h60);
    send(4'h4, 4'h1, 4'h7, 8'h73);
    repeat (3) @(negedge clk);
    send(4'h6, 4'h5, 4'h4, 8'h41);
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    chk("mrst_rsp_valid", {7'b0, rsp_valid}, 8'h00);
    chk("mrst_rsp_data", rsp_data, 8'h00);
    chk("mrst_alu_ui", alu_ui, 8'h00);
    chk("mrst_alu_uio", alu_uio, 8'h00);
    chk("mrst_busy", {7'b0, busy}, 8'h00);
    chk("mrst_cmd_ready", {7'b0, cmd_ready}, 8'h00);
    repeat (2) @(negedge clk);
    chk("mrst_cmd_ready_held", {7'b0, cmd_ready}, 8'h00);
    rst_n = 1'b1;
    @(negedge clk);
    chk("mrst_cmd_ready_rel", {7'b0, cmd_ready}, 8'h01);
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    repeat (10) @(negedge clk);
    chk("mrst_no_stale", {7'b0, rsp_valid}, 8'h00);

    // Statistics: 257 commands, carry set on exactly three
    @(posedge clk); #1;
    for (int i = 0; i < 257; i++) begin
      s = (i == 5 || i == 128 || i == 250) ? 4'h9 : 4'h1;
      send(4'(i), 4'(i >> 4), s, exp_of(4'(i), 4'(i >> 4), s));
    end
    wait_drain();
`ifdef ALU_DRV_STATS_EN
    chk("stat_cmds", stat_cmds, 8'h01);
    chk("stat_carry", stat_carry, 8'h03);
`else
    chk("stat_cmds", stat_cmds, 8'h00);
    chk("stat_carry", stat_carry, 8'h00);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
